// File: rtl/param_dmux_seq_if.sv
// Handshake and demux-drive bundle between a bit source, the frame
// sequencer and the downstream 1-to-N demultiplexer.
interface param_dmux_seq_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned SW = $clog2(N);

  logic          start;
  logic [N-1:0]  mask;
  logic          in_valid;
  logic          in_data;
  logic          in_ready;
  logic [SW-1:0] sel;
  logic          dout;
  logic          strobe;
  logic          busy;
  logic          done;

  modport master (
    output start, mask, in_valid, in_data,
    input  in_ready, sel, dout, strobe, busy, done
  );

  modport slave (
    input  start, mask, in_valid, in_data,
    output in_ready, sel, dout, strobe, busy, done
  );
endinterface

// File: rtl/param_dmux_seq.sv
// Frame sequencer: strobes one accepted serial bit per enabled channel of the
// latched mask, in ascending channel order, onto a 1-to-N demux selector.
module param_dmux_seq #(
  parameter int unsigned N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  param_dmux_seq_if.slave   bus
);
  localparam int unsigned SW = $clog2(N);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [SW-1:0] cur_q, cur_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          dout_q, dout_d;
  logic          strobe_q, strobe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [SW-1:0] first_idx;
  logic [SW-1:0] next_idx;
  logic          next_found;

  // Lowest set bit of the incoming mask; only consulted when mask != 0.
  always_comb begin
    first_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (bus.mask[i]) first_idx = SW'(i);
    end
  end

  // Lowest latched-mask bit strictly above the current channel.
  always_comb begin
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(cur_q))) begin
        next_idx   = SW'(i);
        next_found = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cur_d    = cur_q;
    sel_d    = sel_q;
    dout_d   = 1'b0;
    strobe_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (|bus.mask) begin
            mask_d  = bus.mask;
            cur_d   = first_idx;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          sel_d    = cur_q;
          dout_d   = bus.in_data;
          strobe_d = 1'b1;
          if (next_found) begin
            cur_d = next_idx;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      cur_q    <= '0;
      sel_q    <= '0;
      dout_q   <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      cur_q    <= cur_d;
      sel_q    <= sel_d;
      dout_q   <= dout_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Ready depends on state only, so the source may key in_valid off it.
  assign bus.in_ready = (state_q == RUN);
  assign bus.sel      = sel_q;
  assign bus.dout     = dout_q;
  assign bus.strobe   = strobe_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule
